// File: rtl/bft_pkg.sv
// Shared BFT packet layout, credit sizing and sender state types.
// Imported by the leaf stream sender and its credit counter.
package bft_pkg;

  localparam int PACKET_BITS           = 49;
  localparam int PAYLOAD_BITS          = 32;
  localparam int NUM_LEAF_BITS         = 3;
  localparam int NUM_PORT_BITS         = 4;
  localparam int NUM_BRAM_ADDR_BITS    = 7;
  localparam int FREESPACE_UPDATE_SIZE = 64;
  localparam int CNT_BITS              = NUM_BRAM_ADDR_BITS + 1;
  localparam int MAX_CREDITS           = 2 ** NUM_BRAM_ADDR_BITS;

  localparam int VALID_BIT    = 48;
  localparam int DST_LEAF_LSB = 45;
  localparam int DST_PORT_LSB = 41;
  localparam int SRC_LEAF_LSB = 38;
  localparam int SRC_PORT_LSB = 34;
  localparam int TYPE_LSB     = 32;

  localparam logic [1:0] TYPE_DATA      = 2'b00;
  localparam logic [1:0] TYPE_FREESPACE = 2'b01;

  typedef struct packed {
    logic                     valid;
    logic [NUM_LEAF_BITS-1:0] dst_leaf;
    logic [NUM_PORT_BITS-1:0] dst_port;
    logic [NUM_LEAF_BITS-1:0] src_leaf;
    logic [NUM_PORT_BITS-1:0] src_port;
    logic [1:0]               ptype;
    logic [PAYLOAD_BITS-1:0]  payload;
  } bft_pkt_t;

  typedef enum logic {
    IDLE,
    SENT
  } state_t;

endpackage

// File: rtl/bft_credit_counter.sv
// Saturating credit counter: one decrement per capture plus
// clamped freespace refills, capped at the remote buffer depth.
module bft_credit_counter
  import bft_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                dec,
  input  logic                add_vld,
  input  logic [7:0]          add_val,
  output logic [CNT_BITS-1:0] count,
  output logic                nonzero
);

  logic [CNT_BITS-1:0] cnt_q;
  logic [7:0]          add_c;
  logic [CNT_BITS:0]   sum;

  // Clamp the refill, combine with the decrement, saturate at max
  always_comb begin
    add_c = 8'd0;
    if (add_vld) begin
      if (add_val > 8'(FREESPACE_UPDATE_SIZE))
        add_c = 8'(FREESPACE_UPDATE_SIZE);
      else
        add_c = add_val;
    end
    sum = {1'b0, cnt_q} + {1'b0, add_c} - (CNT_BITS+1)'(dec);
    if (sum > (CNT_BITS+1)'(MAX_CREDITS))
      sum = (CNT_BITS+1)'(MAX_CREDITS);
  end

  // Credit register; full buffer after reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt_q <= CNT_BITS'(MAX_CREDITS);
    else
      cnt_q <= sum[CNT_BITS-1:0];
  end

  assign count   = cnt_q;
  assign nonzero = (cnt_q != '0);

endmodule

// File: rtl/leaf_stream_sender.sv
// Transmit endpoint for one BFT stream: wraps producer words into
// packets, retransmits on resend, and stalls when out of credit.
module leaf_stream_sender
  import bft_pkg::*;
#(
  parameter logic [2:0] SRC_LEAF = 3'd0,
  parameter logic [3:0] SRC_PORT = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  cfg_dst_leaf,
  input  logic [3:0]  cfg_dst_port,
  input  logic [31:0] din_user2sender,
  input  logic        vld_user2sender,
  output logic        ack_sender2user,
  input  logic [48:0] din_leaf_bft2sender,
  output logic [48:0] dout_leaf_sender2bft,
  input  logic        resend,
  output logic [7:0]  credits
);

  state_t   state_q, state_d;
  bft_pkt_t pkt_q;
  bft_pkt_t dout_q, dout_d;
  bft_pkt_t cap_pkt;
  bft_pkt_t ret;
  logic     ack;
  logic     resend_eff;
  logic     has_credit;
  logic     upd_hit;
  logic     unused_ret;

  assign ret = din_leaf_bft2sender;

  assign upd_hit = ret.valid
                && (ret.dst_leaf == SRC_LEAF)
                && (ret.dst_port == SRC_PORT)
                && (ret.ptype == TYPE_FREESPACE);

  assign unused_ret = ^{ret.src_leaf, ret.src_port,
                        ret.payload[31:8]};

  bft_credit_counter u_credits (
    .clk     (clk),
    .reset   (reset),
    .dec     (ack),
    .add_vld (upd_hit),
    .add_val (ret.payload[7:0]),
    .count   (credits),
    .nonzero (has_credit)
  );

  // Capture decision, packet build and next-state selection
  always_comb begin
    state_d          = state_q;
    dout_d           = '0;
    cap_pkt          = '0;
    cap_pkt.valid    = 1'b1;
    cap_pkt.dst_leaf = cfg_dst_leaf;
    cap_pkt.dst_port = cfg_dst_port;
    cap_pkt.src_leaf = SRC_LEAF;
    cap_pkt.src_port = SRC_PORT;
    cap_pkt.ptype    = TYPE_DATA;
    cap_pkt.payload  = din_user2sender;
    resend_eff       = (state_q == SENT) && resend;
    ack              = reset && vld_user2sender
                    && has_credit && !resend_eff;
    unique case (state_q)
      IDLE: begin
        if (ack) begin
          dout_d  = cap_pkt;
          state_d = SENT;
        end
      end
      SENT: begin
        if (resend) begin
          dout_d = pkt_q;
        end else if (ack) begin
          dout_d = cap_pkt;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, output packet and retained copy for retransmission
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pkt_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      if (ack)
        pkt_q <= cap_pkt;
    end
  end

  assign ack_sender2user      = ack;
  assign dout_leaf_sender2bft = dout_q;

endmodule

// File: tb/tb_leaf_stream_sender.sv
// Self-checking bench for leaf_stream_sender: cycle model with
// packet scoreboard plus a table of credit-update vectors.
module tb_leaf_stream_sender;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  dst_leaf;
  logic [3:0]  dst_port;
  logic [31:0] din;
  logic        vld;
  logic        ack;
  logic [48:0] ret_pkt;
  logic [48:0] dout;
  logic        resend;
  logic [7:0]  credits;

  leaf_stream_sender dut (
    .clk                  (clk),
    .reset                (reset),
    .cfg_dst_leaf         (dst_leaf),
    .cfg_dst_port         (dst_port),
    .din_user2sender      (din),
    .vld_user2sender      (vld),
    .ack_sender2user      (ack),
    .din_leaf_bft2sender  (ret_pkt),
    .dout_leaf_sender2bft (dout),
    .resend               (resend),
    .credits              (credits)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  int          m_cred;
  bit          m_sent;
  logic [48:0] m_last;
  logic [48:0] exp_q[$];
  int          idx;

  typedef struct {
    logic       v;
    logic [2:0] l;
    logic [3:0] p;
    logic [1:0] t;
    logic [7:0] pay;
    int         exp_cred;
  } vec_t;

  vec_t tbl[8];

  task automatic check(string name, logic [63:0] act,
                       logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [48:0] mk(logic [2:0] l, logic [3:0] p,
                                     logic [31:0] d);
    return {1'b1, l, p, 3'd0, 4'd1, 2'b00, d};
  endfunction

  function automatic int model_add(logic [48:0] r);
    int p;
    if (r[48] && r[47:45] == 3'd0 && r[44:41] == 4'd1
        && r[33:32] == 2'b01) begin
      p = int'(r[7:0]);
      return (p > 64) ? 64 : p;
    end
    return 0;
  endfunction

  function automatic logic [48:0] upd(logic [2:0] l, logic [3:0] p,
                                      logic [1:0] t, logic [7:0] n);
    return {1'b1, l, p, 3'd5, 4'd7, t, 24'h0, n};
  endfunction

  // One clock: inputs set at negedge before the call
  task automatic tick(output bit acked);
    bit          ea;
    int          n;
    logic [48:0] exp_d;
    #1;
    ea = vld && (m_cred > 0) && !(m_sent && resend);
    check("ack", ack, ea);
    acked = ack;
    if (ea) exp_q.push_back(mk(dst_leaf, dst_port, din));
    n = m_cred - int'(ea) + model_add(ret_pkt);
    if (n > 128) n = 128;
    @(posedge clk);
    #1;
    if (ea) begin
      exp_d = exp_q.pop_front();
      m_last = exp_d;
    end else if (m_sent && resend) begin
      exp_d = m_last;
    end else begin
      exp_d = '0;
    end
    check("dout", dout, exp_d);
    check("credits", credits, n);
    m_sent = ea || (m_sent && resend);
    m_cred = n;
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_cred = 128;
    m_sent = 0;
    m_last = '0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_dout", dout, 0);
    check("rst_ack", ack, 0);
    check("rst_credits", credits, 128);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic set_word();
    din      = 32'hC000_0000 + idx;
    dst_leaf = idx[2:0];
    dst_port = idx[6:3];
  endtask

  task automatic stream_until(int target, int budget);
    bit a;
    vld = 1'b1;
    for (int c = 0; c < budget && m_cred != target; c++) begin
      set_word();
      tick(a);
      if (a) idx++;
    end
    check("stream_target", credits, target);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit a;
    int acks;
    int appear;
    reset    = 1'b0;
    vld      = 1'b0;
    din      = '0;
    dst_leaf = '0;
    dst_port = '0;
    ret_pkt  = '0;
    resend   = 1'b0;
    idx      = 0;
    model_reset();

    tbl[0] = '{1'b1, 3'd0, 4'd1, 2'b01, 8'd10,  10};
    tbl[1] = '{1'b1, 3'd1, 4'd1, 2'b01, 8'd20,  10};
    tbl[2] = '{1'b1, 3'd0, 4'd2, 2'b01, 8'd20,  10};
    tbl[3] = '{1'b1, 3'd0, 4'd1, 2'b00, 8'd20,  10};
    tbl[4] = '{1'b0, 3'd0, 4'd1, 2'b01, 8'd20,  10};
    tbl[5] = '{1'b1, 3'd0, 4'd1, 2'b01, 8'd200, 74};
    tbl[6] = '{1'b1, 3'd0, 4'd1, 2'b01, 8'd64,  128};
    tbl[7] = '{1'b1, 3'd0, 4'd1, 2'b01, 8'd0,   128};

    do_reset();

    // single word
    vld      = 1'b1;
    din      = 32'hDEADBEEF;
    dst_leaf = 3'd3;
    dst_port = 4'd2;
    tick(a);
    vld = 1'b0;
    check("single_pkt", dout,
          {1'b1, 3'd3, 4'd2, 3'd0, 4'd1, 2'b00, 32'hDEADBEEF});
    check("single_cred", credits, 127);
    tick(a);

    // 130 offered words, only 128 credits
    do_reset();
    vld  = 1'b1;
    acks = 0;
    for (int c = 0; c < 140; c++) begin
      set_word();
      tick(a);
      if (a) begin
        acks++;
        idx++;
      end
      if (acks >= 130) break;
    end
    check("acks_128", acks, 128);
    check("cred_zero", credits, 0);
    ret_pkt = upd(3'd0, 4'd1, 2'b01, 8'd64);
    set_word();
    tick(a);
    check("no_ack_on_upd", a, 0);
    ret_pkt = '0;
    acks = 0;
    for (int c = 0; c < 80; c++) begin
      set_word();
      tick(a);
      if (a) begin
        acks++;
        idx++;
      end
    end
    check("acks_64", acks, 64);
    check("cred_zero2", credits, 0);
    vld = 1'b0;
    tick(a);

    // resend holds the same packet, no acks meanwhile
    do_reset();
    vld      = 1'b1;
    din      = 32'hA5A5_0001;
    dst_leaf = 3'd1;
    dst_port = 4'd3;
    tick(a);
    appear = (dout === mk(3'd1, 4'd3, 32'hA5A5_0001)) ? 1 : 0;
    din    = 32'hA5A5_0002;
    resend = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick(a);
      if (dout === mk(3'd1, 4'd3, 32'hA5A5_0001)) appear++;
    end
    check("resend_4x", appear, 4);
    check("resend_cred", credits, 127);
    resend = 1'b0;
    tick(a);
    vld = 1'b0;
    tick(a);
    resend = 1'b1;
    tick(a);
    check("idle_resend", dout, 0);
    resend = 1'b0;

    // credit update table from empty
    do_reset();
    stream_until(0, 140);
    vld = 1'b0;
    tick(a);
    foreach (tbl[i]) begin
      ret_pkt = {tbl[i].v, tbl[i].l, tbl[i].p, 3'd5, 4'd7,
                 tbl[i].t, 24'h0, tbl[i].pay};
      tick(a);
      ret_pkt = '0;
      check("tbl_cred", credits, tbl[i].exp_cred);
    end

    // capture and refill together at 100
    do_reset();
    stream_until(100, 40);
    set_word();
    ret_pkt = upd(3'd0, 4'd1, 2'b01, 8'd64);
    tick(a);
    ret_pkt = '0;
    check("sim_sat", credits, 128);
    idx++;
    set_word();
    tick(a);
    vld = 1'b0;
    ret_pkt = upd(3'd0, 4'd2, 2'b01, 8'd64);
    tick(a);
    ret_pkt = '0;
    check("other_port", credits, 127);

    // back-to-back, changing destination each word
    do_reset();
    vld = 1'b1;
    for (int i = 0; i < 10; i++) begin
      din      = 32'hB000_0000 + i;
      dst_leaf = 3'(i);
      dst_port = 4'(9 - i);
      tick(a);
      check("b2b_valid", dout[48], 1);
    end
    vld = 1'b0;
    tick(a);

    // asynchronous reset mid-stream
    do_reset();
    stream_until(50, 90);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_dout", dout, 0);
    check("async_ack", ack, 0);
    check("async_cred", credits, 128);
    @(negedge clk);
    reset = 1'b1;
    vld   = 1'b0;
    model_reset();
    tick(a);
    check("post_rst_cred", credits, 128);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/leaf_stream_sender.md
Name: leaf_stream_sender

Overview:
- Transmit-side endpoint for one BFT stream.
- Accepts 32-bit words from a producer over the ap_vld/ap_ack handshake and emits 49-bit BFT packets toward a remote leaf input port.
- Flow control is credit-based. Credits come back as freespace-update packets on the return path.
- Sits on the host/DMA side of the tree and drives packets into leaf ports such as Input_1 of a leaf.

Parameters:
- PACKET_BITS, 49, packet width.
- PAYLOAD_BITS, 32, data field width.
- NUM_LEAF_BITS, 3, leaf address width.
- NUM_PORT_BITS, 4, port address width.
- NUM_BRAM_ADDR_BITS, 7, remote receive buffer depth is 2^N = 128 words.
- FREESPACE_UPDATE_SIZE, 64, maximum credits carried by one update packet.
- SRC_LEAF, 0, this endpoint's leaf id, inserted in the header.
- SRC_PORT, 1, this endpoint's port id, inserted in the header.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- cfg_dst_leaf  in  3  destination leaf; sampled per word.
- cfg_dst_port  in  4  destination port; sampled per word.
- din_user2sender  in  32  producer data.
- vld_user2sender  in  1  producer data valid.
- ack_sender2user  out  1  word consumed this cycle.
- din_leaf_bft2sender  in  49  return-path packets carrying credit updates.
- dout_leaf_sender2bft  out  49  outgoing packet; bit 48 = valid.
- resend  in  1  tree rejected the packet driven last cycle.
- credits  out  8  current credit count, for debug.

Behaviour:
- Packet layout:
  - [48] valid
  - [47:45] dst_leaf
  - [44:41] dst_port
  - [40:38] src_leaf
  - [37:34] src_port
  - [33:32] type: 00 data, 01 freespace update
  - [31:0] payload
- Reset (reset=0, async) clears:
  - dout_leaf_sender2bft = 0
  - ack_sender2user = 0
  - retained packet = 0
  - credits = 128
  - state = IDLE
- FSM has two states, IDLE and SENT:
  - IDLE: if vld_user2sender=1 and credits>0, capture the word. Pulse ack_sender2user for exactly 1 cycle in that capture cycle (combinational from the same condition). Next edge: drive the data packet with valid=1 and go to SENT. Latency from vld to packet on output is 1 cycle.
  - SENT: if resend=1, re-drive the identical retained packet next cycle. Stay in SENT; no ack and no credit change.
  - SENT with resend=0 and a new word eligible: back-to-back capture, so one word per cycle is sustained.
  - SENT with resend=0 and no eligible word: output 0 next cycle, go to IDLE.
- Credits:
  - Width NUM_BRAM_ADDR_BITS+1 (8 bits), range 0..128.
  - Decrement by 1 on each capture.
  - A return packet with valid=1, dst matching SRC_LEAF/SRC_PORT, and type=01 adds payload[7:0].
  - The sum saturates at 128. Update payloads above FREESPACE_UPDATE_SIZE are clamped to it.
  - Capture and update in the same cycle: next = min(128, cnt - 1 + n).
  - With credits=0, ack stays low and vld is held off. An update arriving that cycle permits capture from the following cycle, not combinationally.
  - Non-matching or type=00 return packets are ignored.
- Handshake rules:
  - The producer holds din and vld until it sees ack.
  - The sender never acks while credits=0 or while resend=1.
- Resend asserted in IDLE, when no packet was driven last cycle, is ignored.
- Destination fields are sampled at capture. Changing cfg mid-stream affects only later words.
- Reset asserted mid-packet drops the retained packet. Credits return to 128; the remote side is reset with it.

Decomposition:
- Package bft_pkg holds:
  - field offsets and widths
  - TYPE_DATA=2'b00, TYPE_FREESPACE=2'b01
  - MAX_CREDITS = 2**NUM_BRAM_ADDR_BITS
- Sub-module bft_credit_counter: saturating up/down counter with decrement enable, add value, clamp, and a credits>0 flag.
- Packet formatting and the FSM stay in the top.

Test Plan:
- Reset then a single word: din=32'hDEADBEEF, dst 3/2 → ack pulses in the capture cycle. The next cycle dout = {1,3'd3,4'd2,SRC_LEAF,SRC_PORT,2'b00,32'hDEADBEEF}. Credits go 128→127.
- Stream of 130 words with no updates → exactly 128 acks, then ack stays low and credits=0. Send an update with payload 64 → 64 more words are accepted and credits reach 0 again.
- Resend=1 for 3 cycles after a packet → the same packet appears 4 times total, no extra ack, credits unchanged.
- Simultaneous capture and update of 64 at credits=100 → credits=128 (saturated). Update packet addressed to another port → credits unchanged.
- Back-to-back vld for 10 cycles → 10 consecutive valid packets with no bubbles, and payload order preserved.
- Assert reset mid-stream at credits=50 → outputs go to 0 immediately (async), and credits=128 after release.
